load_power_arbiter: RTL and testbench

Shares the appliance's limited mains power budget between the four switched loads: drain pump, water valve, drum motor and heater. The wash-cycle controller raises a load request; this block decides when the corresponding load-enable is actually granted. It staggers inrush so that at most one load turns on per settle window, enforces minimum on/off times against short-cycling, and can preempt a lower-priority load for a higher-priority one. It sits between the cycle FSM outputs and the load driver pins.

---
 rtl/wm_load_pkg.sv | 31 +++
 rtl/load_hold_timer.sv | 53 +++++
 rtl/load_power_arbiter.sv | 156 +++++++++++++++
 tb/tb_load_power_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wm_load_pkg.sv
// Shared types and defaults for the washing-machine load power arbiter.
package wm_load_pkg;

  localparam int unsigned NumLoads = 4;
  localparam int unsigned PwrW     = 10;

  typedef enum logic [1:0] {
    LOAD_PUMP   = 2'd0,
    LOAD_VALVE  = 2'd1,
    LOAD_MOTOR  = 2'd2,
    LOAD_HEATER = 2'd3
  } load_e;

  typedef enum logic [1:0] {
    StIdle,
    StStagger,
    StFault
  } arb_state_e;

  localparam int unsigned DefWPump       = 10;
  localparam int unsigned DefWValve      = 5;
  localparam int unsigned DefWMotor      = 50;
  localparam int unsigned DefWHeater     = 200;
  localparam int unsigned DefPowerBudget = 220;

  // Bits needed to hold 0..max_val, never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/load_hold_timer.sv
// Saturating on/off hold counters for one load; each reads "expired" at its limit.
module load_hold_timer
  import wm_load_pkg::*;
#(
  parameter int unsigned MinOn  = 8,
  parameter int unsigned MinOff = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_on_i,
  input  logic start_off_i,
  output logic on_expired_o,
  output logic off_expired_o
);

  localparam int unsigned OnW  = cnt_width(MinOn);
  localparam int unsigned OffW = cnt_width(MinOff);
  localparam logic [OnW-1:0]  OnLim  = OnW'(MinOn);
  localparam logic [OffW-1:0] OffLim = OffW'(MinOff);

  logic [OnW-1:0]  on_q, on_d;
  logic [OffW-1:0] off_q, off_d;

  always_comb begin
    on_d  = on_q;
    off_d = off_q;
    if (start_on_i) begin
      on_d = '0;
    end else if (on_q != OnLim) begin
      on_d = on_q + 1'b1;
    end
    if (start_off_i) begin
      off_d = '0;
    end else if (off_q != OffLim) begin
      off_d = off_q + 1'b1;
    end
  end

  // Off-timer resets expired so every load is grantable straight out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      on_q  <= '0;
      off_q <= OffLim;
    end else begin
      on_q  <= on_d;
      off_q <= off_d;
    end
  end

  assign on_expired_o  = (on_q == OnLim);
  assign off_expired_o = (off_q == OffLim);

endmodule

// File: rtl/load_power_arbiter.sv
// Grants mains power to four loads with inrush staggering and min on/off hold times.
// Optional preemption of lower-priority loads is enabled by LOAD_ARB_PREEMPT_EN.
module load_power_arbiter
  import wm_load_pkg::*;
#(
  parameter int unsigned W_PUMP         = DefWPump,
  parameter int unsigned W_VALVE        = DefWValve,
  parameter int unsigned W_MOTOR        = DefWMotor,
  parameter int unsigned W_HEATER       = DefWHeater,
  parameter int unsigned POWER_BUDGET   = DefPowerBudget,
  parameter int unsigned STAGGER_CYCLES = 4,
  parameter int unsigned MIN_ON_CYCLES  = 8,
  parameter int unsigned MIN_OFF_CYCLES = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumLoads-1:0] req_i,
  input  logic                fault_i,
  output logic [NumLoads-1:0] gnt_o,
  output logic [PwrW-1:0]     power_used_o,
  output logic                busy_o
);

  localparam int unsigned StgW = cnt_width(STAGGER_CYCLES);
  localparam logic [StgW-1:0] StgLoad = StgW'(STAGGER_CYCLES);

  if (W_PUMP + W_VALVE + W_MOTOR + W_HEATER > (1 << PwrW) - 1) begin : g_weight_overflow
    $error("load_power_arbiter: total load weight does not fit the power_used width");
  end

  arb_state_e          state_q, state_d;
  logic [StgW-1:0]     stg_q, stg_d;
  logic [NumLoads-1:0] gnt_q, gnt_d;
  logic [PwrW-1:0]     power_q, power_d;

  logic [NumLoads-1:0] on_exp, off_exp, start_on, start_off, elig;
  logic [PwrW-1:0]     wt [NumLoads];
  logic [PwrW-1:0]     kept_pwr;
  logic [1:0]          pick;
  logic                pick_vld, fits;

  assign wt[LOAD_PUMP]   = PwrW'(W_PUMP);
  assign wt[LOAD_VALVE]  = PwrW'(W_VALVE);
  assign wt[LOAD_MOTOR]  = PwrW'(W_MOTOR);
  assign wt[LOAD_HEATER] = PwrW'(W_HEATER);

`ifdef LOAD_ARB_PREEMPT_EN
  logic [1:0] vic;
  logic       vic_vld;
`else
  logic [NumLoads-1:0] unused_on_exp;
  assign unused_on_exp = on_exp;
`endif

  always_comb begin
    state_d  = state_q;
    stg_d    = stg_q;
    // Releases apply in every state, and the budget check sees them already removed.
    gnt_d    = gnt_q & req_i;
    elig     = req_i & ~gnt_q & off_exp;
    pick_vld = 1'b0;
    pick     = '0;
    for (int i = int'(NumLoads) - 1; i >= 0; i--) begin
      if (elig[i]) begin
        pick_vld = 1'b1;
        pick     = 2'(i);
      end
    end
    kept_pwr = '0;
    for (int unsigned i = 0; i < NumLoads; i++) begin
      if (gnt_d[i]) kept_pwr = kept_pwr + wt[i];
    end
    fits = (32'(kept_pwr) + 32'(wt[pick])) <= POWER_BUDGET;
`ifdef LOAD_ARB_PREEMPT_EN
    vic_vld = 1'b0;
    vic     = '0;
    for (int unsigned j = 0; j < NumLoads; j++) begin
      if (gnt_d[j] && on_exp[j] && (2'(j) > pick)) begin
        vic_vld = 1'b1;
        vic     = 2'(j);
      end
    end
`endif

    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          if (fits) begin
            gnt_d[pick] = 1'b1;
            stg_d       = StgLoad;
            state_d     = StStagger;
          end
`ifdef LOAD_ARB_PREEMPT_EN
          else if (vic_vld) begin
            gnt_d[vic] = 1'b0;
            stg_d      = StgLoad;
            state_d    = StStagger;
          end
`endif
        end
      end
      StStagger: begin
        stg_d = stg_q - 1'b1;
        if (stg_q == StgW'(1)) state_d = StIdle;
      end
      StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (fault_i) begin
      state_d = StFault;
      gnt_d   = '0;
    end

    power_d = '0;
    for (int unsigned i = 0; i < NumLoads; i++) begin
      if (gnt_d[i]) power_d = power_d + wt[i];
    end
  end

  assign start_on  = gnt_d & ~gnt_q;
  assign start_off = gnt_q & ~gnt_d;

  for (genvar g = 0; g < int'(NumLoads); g++) begin : g_timer
    load_hold_timer #(
      .MinOn  (MIN_ON_CYCLES),
      .MinOff (MIN_OFF_CYCLES)
    ) u_timer (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .start_on_i    (start_on[g]),
      .start_off_i   (start_off[g]),
      .on_expired_o  (on_exp[g]),
      .off_expired_o (off_exp[g])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      stg_q   <= '0;
      gnt_q   <= '0;
      power_q <= '0;
    end else begin
      state_q <= state_d;
      stg_q   <= stg_d;
      gnt_q   <= gnt_d;
      power_q <= power_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign power_used_o = power_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_load_power_arbiter.sv
// Self-checking bench for load_power_arbiter against a timestamp-based reference model.
module tb_load_power_arbiter;

  localparam int W [4] = '{10, 5, 50, 200};
  localparam int BUDGET  = 220;
  localparam int STG     = 4;
  localparam int MIN_ON  = 8;
  localparam int MIN_OFF = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       fault;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [9:0] pwr;
  logic       busy;

  int vectors = 0;
  int errors  = 0;

  // Reference model: edge index, last grant/clear edge per load, first edge a new
  // grant decision may be taken, and whether the arbiter is parked in fault.
  int         n;
  logic [3:0] m_gnt;
  int         m_on [4];
  int         m_clr [4];
  int         m_idle_from;
  bit         m_fault;

  load_power_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .fault_i      (fault),
    .gnt_o        (gnt),
    .power_used_o (pwr),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  function automatic int model_pwr(logic [3:0] g);
    int s = 0;
    for (int i = 0; i < 4; i++) if (g[i]) s += W[i];
    return s;
  endfunction

  function automatic logic m_busy();
    return m_fault || (m_idle_from > n);
  endfunction

  function automatic void model_edge(logic [3:0] r, logic f);
    logic [3:0] nxt;
    int pick;
    int vic;
    if (f) begin
      for (int i = 0; i < 4; i++) if (m_gnt[i]) m_clr[i] = n;
      m_gnt   = '0;
      m_fault = 1'b1;
      return;
    end
    if (m_fault) begin
      m_fault     = 1'b0;
      m_idle_from = n + 1;
      return;
    end
    nxt = m_gnt & r;
    for (int i = 0; i < 4; i++) if (m_gnt[i] && !r[i]) m_clr[i] = n;
    if (n >= m_idle_from) begin
      pick = -1;
      for (int i = 3; i >= 0; i--) if (r[i] && !m_gnt[i] && (n - m_clr[i] > MIN_OFF)) pick = i;
      if (pick >= 0) begin
        if (model_pwr(nxt) + W[pick] <= BUDGET) begin
          nxt[pick]   = 1'b1;
          m_on[pick]  = n;
          m_idle_from = n + STG + 1;
        end else begin
          vic = -1;
`ifdef LOAD_ARB_PREEMPT_EN
          for (int j = pick + 1; j < 4; j++) if (nxt[j] && (n - m_on[j] > MIN_ON)) vic = j;
`endif
          if (vic >= 0) begin
            nxt[vic]    = 1'b0;
            m_clr[vic]  = n;
            m_idle_from = n + STG + 1;
          end
        end
      end
    end
    m_gnt = nxt;
  endfunction

  task automatic tick(input logic [3:0] r, input logic f);
    req   = r;
    fault = f;
    @(posedge clk);
    model_edge(r, f);
    n++;
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req   = '0;
    fault = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n           = 0;
    m_gnt       = '0;
    m_fault     = 1'b0;
    m_idle_from = 0;
    for (int i = 0; i < 4; i++) begin
      m_on[i]  = -1000;
      m_clr[i] = -1000;
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL reset_gnt: got %b want 0000", gnt);
    end
    vectors++;
    if (pwr !== 10'd0) begin
      errors++;
      $display("FAIL reset_power: got %0d want 0", pwr);
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_priority_stagger();
    logic [3:0] exp_g [3] = '{4'b0001, 4'b0011, 4'b0111};
    int         exp_p [3] = '{10, 15, 65};
    do_reset();
    for (int e = 0; e < 25; e++) begin
      tick(4'b1111, 1'b0);
      vectors++;
      if ({gnt, pwr, busy} !== {m_gnt, 10'(model_pwr(m_gnt)), m_busy()}) begin
        errors++;
        $display("FAIL prio edge=%0d: got gnt=%b pwr=%0d busy=%b, want gnt=%b pwr=%0d busy=%b",
                 e, gnt, pwr, busy, m_gnt, model_pwr(m_gnt), m_busy());
      end
      if (e % 5 == 0 && e < 15) begin
        vectors++;
        if (gnt !== exp_g[e/5] || pwr !== 10'(exp_p[e/5])) begin
          errors++;
          $display("FAIL prio_step edge=%0d: got gnt=%b pwr=%0d, want gnt=%b pwr=%0d",
                   e, gnt, pwr, exp_g[e/5], exp_p[e/5]);
        end
      end
    end
    vectors++;
    if (gnt[3] !== 1'b0) begin
      errors++;
      $display("FAIL prio_heater: got gnt[3]=%b want 0", gnt[3]);
    end
  endtask

  task automatic test_release_minoff();
    int c;
    c = n;
    for (int k = 0; k < 26; k++) begin
      tick((k < 6) ? 4'b1110 : 4'b1111, 1'b0);
      vectors++;
      if ({gnt, pwr, busy} !== {m_gnt, 10'(model_pwr(m_gnt)), m_busy()}) begin
        errors++;
        $display("FAIL release edge=%0d: got gnt=%b pwr=%0d busy=%b, want gnt=%b pwr=%0d busy=%b",
                 n - 1, gnt, pwr, busy, m_gnt, model_pwr(m_gnt), m_busy());
      end
      if (n - 1 == c || n - 1 == c + 16 || n - 1 == c + 17) begin
        vectors++;
        if (gnt[0] !== ((n - 1) == c + 17)) begin
          errors++;
          $display("FAIL release_pump edge=%0d (clear at %0d): got gnt[0]=%b want %b",
                   n - 1, c, gnt[0], ((n - 1) == c + 17));
        end
      end
    end
  endtask

  task automatic test_fault_stagger();
    do_reset();
    tick(4'b0001, 1'b0);
    tick(4'b0001, 1'b1);
    vectors++;
    if (gnt !== 4'b0000 || pwr !== 10'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fault_entry: got gnt=%b pwr=%0d busy=%b, want gnt=0000 pwr=0 busy=1",
               gnt, pwr, busy);
    end
    for (int k = 0; k < 30; k++) begin
      tick((k < 3) ? 4'b0011 : 4'b1111, k < 2);
      vectors++;
      if ({gnt, pwr, busy} !== {m_gnt, 10'(model_pwr(m_gnt)), m_busy()}) begin
        errors++;
        $display("FAIL fault edge=%0d: got gnt=%b pwr=%0d busy=%b, want gnt=%b pwr=%0d busy=%b",
                 n - 1, gnt, pwr, busy, m_gnt, model_pwr(m_gnt), m_busy());
      end
      if (n - 1 == 5) begin
        vectors++;
        if (gnt !== 4'b0010) begin
          errors++;
          $display("FAIL fault_regrant: got gnt=%b want 0010 (pump still in min-off)", gnt);
        end
      end
    end
  endtask

  task automatic test_preempt();
    logic [3:0] r;
    logic [3:0] want;
    do_reset();
    for (int e = 0; e < 31; e++) begin
      r = (e < 10) ? 4'b1000 : 4'b1100;
`ifndef LOAD_ARB_PREEMPT_EN
      if (e >= 20) r = 4'b0100;
`endif
      tick(r, 1'b0);
      vectors++;
      if ({gnt, pwr, busy} !== {m_gnt, 10'(model_pwr(m_gnt)), m_busy()}) begin
        errors++;
        $display("FAIL preempt edge=%0d: got gnt=%b pwr=%0d busy=%b, want gnt=%b pwr=%0d busy=%b",
                 e, gnt, pwr, busy, m_gnt, model_pwr(m_gnt), m_busy());
      end
      if (e == 10 || e == 15 || e == 20 || e == 30) begin
`ifdef LOAD_ARB_PREEMPT_EN
        want = (e == 10) ? 4'b0000 : 4'b0100;
`else
        want = (e < 20) ? 4'b1000 : 4'b0100;
`endif
        vectors++;
        if (gnt !== want) begin
          errors++;
          $display("FAIL preempt_step edge=%0d: got gnt=%b want %b", e, gnt, want);
        end
      end
    end
  endtask

  task automatic test_min_on();
    do_reset();
    for (int e = 0; e < 24; e++) begin
      tick((e < 3) ? 4'b1000 : 4'b1100, 1'b0);
      vectors++;
      if ({gnt, pwr, busy} !== {m_gnt, 10'(model_pwr(m_gnt)), m_busy()}) begin
        errors++;
        $display("FAIL min_on edge=%0d: got gnt=%b pwr=%0d busy=%b, want gnt=%b pwr=%0d busy=%b",
                 e, gnt, pwr, busy, m_gnt, model_pwr(m_gnt), m_busy());
      end
      if (e == 8) begin
        vectors++;
        if (gnt !== 4'b1000) begin
          errors++;
          $display("FAIL min_on_hold edge=8: got gnt=%b want 1000", gnt);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r = '0;
    int         fault_left = 0;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(9, 0) == 0) r[i] = ~r[i];
      if (fault_left > 0) fault_left--;
      else if ($urandom_range(149, 0) == 0) fault_left = $urandom_range(6, 1);
      tick(r, fault_left > 0);
      vectors++;
      if ({gnt, pwr, busy} !== {m_gnt, 10'(model_pwr(m_gnt)), m_busy()}) begin
        errors++;
        $display("FAIL random edge=%0d req=%b: got gnt=%b pwr=%0d busy=%b, want gnt=%b pwr=%0d busy=%b",
                 n - 1, r, gnt, pwr, busy, m_gnt, model_pwr(m_gnt), m_busy());
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(4'b0001, 1'b0);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (gnt !== 4'b0000 || pwr !== 10'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got gnt=%b pwr=%0d busy=%b, want gnt=0000 pwr=0 busy=0",
               gnt, pwr, busy);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    fault = 1'b0;
    test_reset();
    test_priority_stagger();
    test_release_minoff();
    test_fault_stagger();
    test_preempt();
    test_min_on();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
